// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver driven by an oversample tick.
// A start bit is qualified at its centre, every data bit and the stop bit
// are sampled at their centres, and each completed frame produces a
// one-cycle strobe with the received word and a framing-error flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle, waiting for a tick that sees rx low
// START | counting to start-bit centre, rejecting glitches
// DATA  | sampling DataBits data bits, LSB first
// STOP  | waiting for stop-bit centre, then strobe and back to IDLE
module uart_rx #(
  parameter int OverSampleRate = 16,
  parameter int DataBits       = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                baud_tick_i,
  input  logic                rx_i,
  output logic [DataBits-1:0] data_o,
  output logic                data_valid_o,
  output logic                frame_err_o,
  output logic                busy_o
);

  localparam int TickW = (OverSampleRate > 1) ? $clog2(OverSampleRate) : 1;
  localparam int BitW  = (DataBits > 1) ? $clog2(DataBits) : 1;

  localparam logic [TickW-1:0] HalfTc = TickW'(OverSampleRate / 2 - 1);
  localparam logic [TickW-1:0] FullTc = TickW'(OverSampleRate - 1);
  localparam logic [BitW-1:0]  LastBit = BitW'(DataBits - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic                r_rx_meta;
  logic                r_rx_s;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TickW-1:0]    r_tick_cnt;
  logic [TickW-1:0]    w_tick_cnt_nxt;
  logic [BitW-1:0]     r_bit_cnt;
  logic [BitW-1:0]     w_bit_cnt_nxt;
  logic [DataBits-1:0] r_shift;
  logic [DataBits-1:0] w_shift_nxt;
  logic [DataBits-1:0] r_data;
  logic [DataBits-1:0] w_data_nxt;
  logic                r_data_valid;
  logic                w_data_valid_nxt;
  logic                r_frame_err;
  logic                w_frame_err_nxt;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
    end
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_data       <= w_data_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  // Next-state logic; everything holds except on baud ticks.
  always_comb begin
    w_state_nxt      = r_state;
    w_tick_cnt_nxt   = r_tick_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_data_nxt       = r_data;
    w_data_valid_nxt = 1'b0;
    w_frame_err_nxt  = r_frame_err;

    if (baud_tick_i) begin
      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            w_state_nxt    = START;
            w_tick_cnt_nxt = '0;
          end
        end

        START: begin
          if (r_tick_cnt == HalfTc) begin
            w_tick_cnt_nxt = '0;
            if (!r_rx_s) begin
              w_state_nxt   = DATA;
              w_bit_cnt_nxt = '0;
            end else begin
              // Start bit gone by its centre: treat as a glitch.
              w_state_nxt = IDLE;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TickW'(1);
          end
        end

        DATA: begin
          if (r_tick_cnt == FullTc) begin
            w_shift_nxt    = {r_rx_s, r_shift[DataBits-1:1]};
            w_tick_cnt_nxt = '0;
            if (r_bit_cnt == LastBit) begin
              w_state_nxt = STOP;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BitW'(1);
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TickW'(1);
          end
        end

        STOP: begin
          // Leaving at stop-bit centre keeps a back-to-back start edge visible.
          if (r_tick_cnt == FullTc) begin
            w_data_nxt       = r_shift;
            w_frame_err_nxt  = ~r_rx_s;
            w_data_valid_nxt = 1'b1;
            w_tick_cnt_nxt   = '0;
            w_state_nxt      = IDLE;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TickW'(1);
          end
        end

        default: begin
          w_state_nxt    = IDLE;
          w_tick_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign data_o       = r_data;
  assign data_valid_o = r_data_valid;
  assign frame_err_o  = r_frame_err;
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a scoreboard of expected frames.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       frame_err_o;
  logic       busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic       tick_en;
  int         tick_div;
  logic [8:0] sb[$];
  time        strobe_times[$];
  logic       prev_valid;
  logic [8:0] mon_exp;

  uart_rx #(.OverSampleRate(16), .DataBits(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .baud_tick_i  (baud_tick),
    .rx_i         (rx),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick: one clock wide, every 4 clocks, can be gated off.
  initial begin
    baud_tick = 1'b0;
    tick_div  = 0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        baud_tick = (tick_div == 0);
        tick_div  = (tick_div + 1) % 4;
      end else begin
        baud_tick = 1'b0;
        tick_div  = 0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: compare each strobe against the oldest expected frame.
  initial prev_valid = 1'b0;
  always @(negedge clk) begin
    if (prev_valid) check("valid_width", {31'd0, data_valid_o}, 32'd0);
    if (data_valid_o) begin
      check("strobe_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        check("data", {24'd0, data_o}, {24'd0, mon_exp[7:0]});
        check("frame_err", {31'd0, frame_err_o}, {31'd0, mon_exp[8]});
      end
      strobe_times.push_back($time);
    end
    prev_valid = data_valid_o;
  end

  task automatic wait_ticks(input int n);
    int guard;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      do begin
        @(posedge clk);
        guard++;
      end while (!baud_tick && guard < 200);
      if (guard >= 200) check("tick_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(n);
  endtask

  // One frame, 16 ticks per bit; optional tick gating inside data bit gate_bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int gate_bit);
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(16);
    check("busy_in_frame", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx = d[i];
      if (i == gate_bit) begin
        wait_ticks(5);
        @(negedge clk);
        tick_en = 1'b0;
        rx = ~d[i];
        repeat (50) @(negedge clk);
        check("busy_gated", {31'd0, busy_o}, 32'd1);
        rx = d[i];
        repeat (4) @(negedge clk);
        tick_en = 1'b1;
        wait_ticks(11);
      end else begin
        wait_ticks(16);
      end
    end
    @(negedge clk);
    rx = stop;
    wait_ticks(16);
  endtask

  initial begin
    int diff;
    rst     = 1'b1;
    rx      = 1'b1;
    tick_en = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", {24'd0, data_o}, 32'd0);
    check("rst_valid", {31'd0, data_valid_o}, 32'd0);
    check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b0;
    idle(32);

    // Nominal byte
    sb.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b1, -1);
    idle(32);
    check("nominal_pending", sb.size(), 32'd0);
    check("nominal_busy_after", {31'd0, busy_o}, 32'd0);

    // False start
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(4);
    check("false_start_busy", {31'd0, busy_o}, 32'd1);
    idle(20);
    check("false_start_idle", {31'd0, busy_o}, 32'd0);
    check("false_start_data", {24'd0, data_o}, 32'hA5);

    // Framing error then a clean frame
    sb.push_back({1'b1, 8'h3C});
    send_frame(8'h3C, 1'b0, -1);
    idle(32);
    check("ferr_pending", sb.size(), 32'd0);
    check("ferr_held", {31'd0, frame_err_o}, 32'd1);
    sb.push_back({1'b0, 8'h00});
    send_frame(8'h00, 1'b1, -1);
    idle(32);
    check("clean_pending", sb.size(), 32'd0);
    check("ferr_cleared", {31'd0, frame_err_o}, 32'd0);

    // Back-to-back frames
    strobe_times.delete();
    sb.push_back({1'b0, 8'h55});
    sb.push_back({1'b0, 8'hFF});
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(32);
    check("b2b_pending", sb.size(), 32'd0);
    check("b2b_strobes", strobe_times.size(), 32'd2);
    diff = 0;
    if (strobe_times.size() >= 2) diff = int'((strobe_times[1] - strobe_times[0]) / 10);
    check("b2b_spacing", {31'd0, (diff >= 636 && diff <= 644)}, 32'd1);

    // Reset during data bit 3 of 0x81
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(16);
    @(negedge clk); rx = 1'b1; wait_ticks(16);
    @(negedge clk); rx = 1'b0; wait_ticks(16);
    @(negedge clk); rx = 1'b0; wait_ticks(16);
    @(negedge clk); rx = 1'b0; wait_ticks(8);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    check("midrst_data", {24'd0, data_o}, 32'd0);
    check("midrst_valid", {31'd0, data_valid_o}, 32'd0);
    check("midrst_ferr", {31'd0, frame_err_o}, 32'd0);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(48);
    check("midrst_pending", sb.size(), 32'd0);
    sb.push_back({1'b0, 8'h42});
    send_frame(8'h42, 1'b1, -1);
    idle(32);
    check("after_rst_pending", sb.size(), 32'd0);
    check("after_rst_data", {24'd0, data_o}, 32'h42);

    // Tick gating mid-frame
    sb.push_back({1'b0, 8'h9B});
    send_frame(8'h9B, 1'b1, 5);
    idle(32);
    check("gated_pending", sb.size(), 32'd0);
    check("gated_data", {24'd0, data_o}, 32'h9B);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
